branch_predictor: RTL and testbench



---
 rtl/branch_predictor.sv | 115 +++++++++++
 tb/tb_branch_predictor.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   Dynamic branch predictor and EX-stage branch resolution.
//   - IF side: combinational lookup of a table of 2-bit saturating counters,
//     indexed by pc[IDX_W+1:2]; prediction is the counter MSB.
//   - EX side: compares the actual outcome with the prediction carried from
//     IF, raises mispredict and supplies the redirect PC, and trains the
//     counter selected by the EX PC on the rising clock edge.
//   Optional build macro: BRANCH_PREDICTOR_STATS_EN adds the 32-bit
//   stat_branches / stat_mispredicts event counters.
// ---------------------------------------------------------------------------
module branch_predictor #(
  parameter int DWIDTH  = 32,
  parameter int ENTRIES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] if_pc,
  output logic              if_pred_taken,
  input  logic              ex_valid,
  input  logic              ex_stall,
  input  logic              ex_is_branch,
  input  logic [DWIDTH-1:0] ex_pc,
  input  logic [DWIDTH-1:0] ex_target,
  input  logic              ex_pred_taken,
  input  logic              ex_taken,
  output logic              mispredict,
  output logic [DWIDTH-1:0] redirect_pc
`ifdef BRANCH_PREDICTOR_STATS_EN
  ,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);

  // Counter encodings: strong/weak not-taken, weak/strong taken.
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_STK = 2'b11;

  // Next counter value: step toward the observed outcome, saturating at the
  // strong states so a single anomaly never flips a strongly-biased branch.
  function automatic logic [1:0] ctr_next(input logic [1:0] cnt,
                                          input logic       taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != CTR_STK) nxt = cnt + 2'd1;
    end else begin
      if (cnt != CTR_SNT) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

  logic [1:0]              r_table [ENTRIES];
  logic [IDX_W-1:0]        w_if_idx;
  logic [IDX_W-1:0]        w_ex_idx;
  logic                    w_upd;
  logic                    w_mispredict;
  logic [DWIDTH-1:0]       w_pc_plus4;
  logic [DWIDTH-IDX_W-1:0] w_unused_if_bits;

  assign w_if_idx = if_pc[IDX_W+1:2];
  assign w_ex_idx = ex_pc[IDX_W+1:2];

  // Only the index bits of the fetch PC select a counter; no tags are kept.
  assign w_unused_if_bits = {if_pc[DWIDTH-1:IDX_W+2], if_pc[1:0]};

  // Lookup reads the registered table directly: no bypass from a same-cycle
  // update, so a colliding update becomes visible one cycle later.
  assign if_pred_taken = r_table[w_if_idx][1];

  // rst_n is part of the qualifier so mispredict is held low during reset,
  // and the AND with ex_valid masks X outcomes from bubbles.
  assign w_upd        = rst_n & ex_valid & ex_is_branch & ~ex_stall;
  assign w_mispredict = w_upd & (ex_taken ^ ex_pred_taken);
  assign mispredict   = w_mispredict;

  // Fall-through address wraps modulo 2^DWIDTH.
  assign w_pc_plus4  = ex_pc + DWIDTH'(4);
  assign redirect_pc = ex_taken ? ex_target : w_pc_plus4;

  // Counter table: reset every entry to weak-NT, train the EX entry on upd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_table[i] <= CTR_WNT;
      end
    end else if (w_upd) begin
      r_table[w_ex_idx] <= ctr_next(r_table[w_ex_idx], ex_taken);
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  // Event counters: resolved branches and mispredicts, free-running wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (w_upd)        r_stat_branches    <= r_stat_branches + 32'd1;
      if (w_mispredict) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
//   Directed, table-driven bench for branch_predictor (ENTRIES=64).
//   Each vector is driven after a falling edge, outputs are compared before
//   the following rising edge, and the table state carries between vectors.
//   Asynchronous reset and post-reset table contents are hand sequenced.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

  localparam int DW = 32;
  localparam int NV = 21;

  typedef struct {
    logic [DW-1:0] if_pc;
    logic          v;
    logic          st;
    logic          br;
    logic [DW-1:0] ex_pc;
    logic [DW-1:0] tgt;
    logic          pt;
    logic          tk;
    logic          e_pred;
    logic          e_mis;
    logic          chk_red;
    logic [DW-1:0] e_red;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] if_pc;
  logic          if_pred_taken;
  logic          ex_valid;
  logic          ex_stall;
  logic          ex_is_branch;
  logic [DW-1:0] ex_pc;
  logic [DW-1:0] ex_target;
  logic          ex_pred_taken;
  logic          ex_taken;
  logic          mispredict;
  logic [DW-1:0] redirect_pc;
`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0]   stat_branches;
  logic [31:0]   stat_mispredicts;
`endif

  int n_cmp;
  int n_fail;
  vec_t vecs [NV];

  branch_predictor #(.DWIDTH(DW), .ENTRIES(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_pc         (if_pc),
    .if_pred_taken (if_pred_taken),
    .ex_valid      (ex_valid),
    .ex_stall      (ex_stall),
    .ex_is_branch  (ex_is_branch),
    .ex_pc         (ex_pc),
    .ex_target     (ex_target),
    .ex_pred_taken (ex_pred_taken),
    .ex_taken      (ex_taken),
    .mispredict    (mispredict),
    .redirect_pc   (redirect_pc)
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [DW-1:0] ipc, input logic v,
                              input logic st, input logic br,
                              input logic [DW-1:0] epc, input logic [DW-1:0] tgt,
                              input logic pt, input logic tk,
                              input logic e_pred, input logic e_mis,
                              input logic chk_red, input logic [DW-1:0] e_red);
    vec_t r;
    r.if_pc = ipc; r.v = v; r.st = st; r.br = br; r.ex_pc = epc; r.tgt = tgt;
    r.pt = pt; r.tk = tk; r.e_pred = e_pred; r.e_mis = e_mis;
    r.chk_red = chk_red; r.e_red = e_red;
    return r;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    if_pc         = t.if_pc;
    ex_valid      = t.v;
    ex_stall      = t.st;
    ex_is_branch  = t.br;
    ex_pc         = t.ex_pc;
    ex_target     = t.tgt;
    ex_pred_taken = t.pt;
    ex_taken      = t.tk;
  endtask

  initial begin
    int exp_br;
    int exp_mp;
    n_cmp  = 0;
    n_fail = 0;
    exp_br = 0;
    exp_mp = 0;

    //           if_pc  v  st br ex_pc         target  pt    tk    pred mis chk red
    vecs[0]  = mk(32'h0,   0, 0, 0, 32'h0,        32'h40,  0,    0,    0, 0, 1, 32'h4);
    vecs[1]  = mk(32'h4,   0, 0, 0, 32'h10,       32'h80,  0,    1,    0, 0, 1, 32'h80);
    vecs[2]  = mk(32'hFC,  0, 0, 0, 32'h10,       32'h80,  0,    0,    0, 0, 1, 32'h14);
    // train idx 0 toward taken: 01 -> 10 -> 11 -> 11
    vecs[3]  = mk(32'h100, 1, 0, 1, 32'h100,      32'h200, 0,    1,    0, 1, 1, 32'h200);
    vecs[4]  = mk(32'h100, 1, 0, 1, 32'h100,      32'h200, 0,    1,    1, 1, 1, 32'h200);
    vecs[5]  = mk(32'h100, 1, 0, 1, 32'h100,      32'h200, 0,    1,    1, 1, 1, 32'h200);
    vecs[6]  = mk(32'h100, 1, 0, 1, 32'h100,      32'h200, 1,    1,    1, 0, 1, 32'h200);
    // two not-taken updates: 11 -> 10 -> 01
    vecs[7]  = mk(32'h100, 1, 0, 1, 32'h100,      32'h200, 1,    0,    1, 1, 1, 32'h104);
    vecs[8]  = mk(32'h100, 1, 0, 1, 32'h100,      32'h200, 1,    0,    1, 1, 1, 32'h104);
    vecs[9]  = mk(32'h100, 0, 0, 0, 32'h100,      32'h200, 0,    0,    0, 0, 1, 32'h104);
    // gating: stall, bubble with unknown outcome, non-branch
    vecs[10] = mk(32'h100, 1, 1, 1, 32'h100,      32'h200, 0,    1,    0, 0, 1, 32'h200);
    vecs[11] = mk(32'h100, 0, 0, 1, 32'h100,      32'h200, 1'bx, 1'bx, 0, 0, 0, 32'h0);
    vecs[12] = mk(32'h100, 1, 0, 0, 32'h100,      32'h200, 0,    1,    0, 0, 1, 32'h200);
    vecs[13] = mk(32'h0,   0, 0, 0, 32'h100,      32'h200, 0,    0,    0, 0, 1, 32'h104);
    // same-index collision: 0x200 aliases 0x100 (idx 0)
    vecs[14] = mk(32'h100, 1, 0, 1, 32'h200,      32'h300, 0,    1,    0, 1, 1, 32'h300);
    vecs[15] = mk(32'h100, 0, 0, 0, 32'h200,      32'h300, 0,    0,    1, 0, 1, 32'h204);
    vecs[16] = mk(32'h104, 0, 0, 0, 32'h200,      32'h300, 0,    0,    0, 0, 1, 32'h204);
    // top PC wraps, idx 0x3F: 01 -> 00 -> 01 -> 10
    vecs[17] = mk(32'hFC,  1, 0, 1, 32'hFFFFFFFC, 32'h10,  1,    0,    0, 1, 1, 32'h0);
    vecs[18] = mk(32'hFC,  1, 0, 1, 32'hFFFFFFFC, 32'h10,  0,    1,    0, 1, 1, 32'h10);
    vecs[19] = mk(32'hFC,  1, 0, 1, 32'hFFFFFFFC, 32'h10,  0,    1,    0, 1, 1, 32'h10);
    vecs[20] = mk(32'hFC,  0, 0, 0, 32'hFFFFFFFC, 32'h10,  0,    0,    1, 0, 1, 32'h0);

    rst_n = 1'b0;
    drive(vecs[0]);
    repeat (2) @(posedge clk);
    #1;
    check("reset_mispredict", {31'd0, mispredict}, 32'd0);
    check("reset_pred", {31'd0, if_pred_taken}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #2;
      check($sformatf("v%0d_pred", i), {31'd0, if_pred_taken}, {31'd0, vecs[i].e_pred});
      check($sformatf("v%0d_mis", i), {31'd0, mispredict}, {31'd0, vecs[i].e_mis});
      if (vecs[i].chk_red)
        check($sformatf("v%0d_redirect", i), redirect_pc, vecs[i].e_red);
`ifdef BRANCH_PREDICTOR_STATS_EN
      check($sformatf("v%0d_stat_br", i), stat_branches, exp_br);
      check($sformatf("v%0d_stat_mp", i), stat_mispredicts, exp_mp);
`endif
      if (vecs[i].v && vecs[i].br && !vecs[i].st) exp_br++;
      if (vecs[i].e_mis) exp_mp++;
    end

    // Asynchronous reset in the middle of an updating cycle.
    @(negedge clk);
    drive(mk(32'h100, 1, 0, 1, 32'h100, 32'h200, 0, 1, 0, 0, 0, 32'h0));
    #1;
    check("pre_arst_pred", {31'd0, if_pred_taken}, 32'd1);
    check("pre_arst_mis", {31'd0, mispredict}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_mis", {31'd0, mispredict}, 32'd0);
    check("arst_pred", {31'd0, if_pred_taken}, 32'd0);
`ifdef BRANCH_PREDICTOR_STATS_EN
    check("arst_stat_br", stat_branches, 32'd0);
    check("arst_stat_mp", stat_mispredicts, 32'd0);
`endif
    @(negedge clk);
    #1;
    check("arst_hold_pred", {31'd0, if_pred_taken}, 32'd0);
    ex_valid = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if_pc = 32'(i) << 2;
      #1;
      check($sformatf("post_rst_entry%0d", i), {31'd0, if_pred_taken}, 32'd0);
    end

    // Training resumes normally after reset.
    @(negedge clk);
    drive(mk(32'h100, 1, 0, 1, 32'h100, 32'h200, 0, 1, 0, 0, 0, 32'h0));
    @(negedge clk);
    ex_valid = 1'b0;
    #1;
    check("post_rst_train_pred", {31'd0, if_pred_taken}, 32'd1);
`ifdef BRANCH_PREDICTOR_STATS_EN
    check("post_rst_stat_br", stat_branches, 32'd1);
    check("post_rst_stat_mp", stat_mispredicts, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
